vga_bounce_rect: RTL and testbench

//   Renders one solid rectangle on a 640x480 VGA raster and moves it once per frame.
//   The rectangle bounces off all four screen edges.

---
 rtl/vga_bounce_rect_if.sv | 24 ++
 rtl/vga_bounce_rect.sv | 172 +++++++++++++++++
 tb/tb_vga_bounce_rect.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_bounce_rect_if.sv
// Raster-position and colour-output bundle between the VGA timing generator,
// the bouncing-rectangle renderer and the DAC pins.
interface vga_bounce_rect_if #(
  parameter int COLOR_BITS = 4
);
  logic [9:0]            pos_h;
  logic [9:0]            pos_v;
  logic                  blank;
  logic                  enable;
  logic [COLOR_BITS-1:0] red;
  logic [COLOR_BITS-1:0] green;
  logic [COLOR_BITS-1:0] blue;
  logic                  bounce;

  modport master (
    output pos_h, pos_v, blank, enable,
    input  red, green, blue, bounce
  );

  modport slave (
    input  pos_h, pos_v, blank, enable,
    output red, green, blue, bounce
  );
endinterface

// File: rtl/vga_bounce_rect.sv
// Draws one solid rectangle on a 640x480 raster and moves it once per frame,
// bouncing off all four edges and rotating the foreground colour on each bounce.
//
// state      | meaning
// FG_MAGENTA | foreground is red + blue
// FG_YELLOW  | foreground is red + green
// FG_CYAN    | foreground is green + blue
module vga_bounce_rect #(
  parameter int WIDTH      = 20,
  parameter int HEIGHT     = 100,
  parameter int X_START    = 320,
  parameter int Y_START    = 240,
  parameter int STEP_X     = 2,
  parameter int STEP_Y     = 1,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int COLOR_BITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  vga_bounce_rect_if.slave vga
);

  localparam logic [10:0] WIDTH_C    = 11'(WIDTH);
  localparam logic [10:0] HEIGHT_C   = 11'(HEIGHT);
  localparam logic [10:0] X_START_C  = 11'(X_START);
  localparam logic [10:0] Y_START_C  = 11'(Y_START);
  localparam logic [10:0] STEP_X_C   = 11'(STEP_X);
  localparam logic [10:0] STEP_Y_C   = 11'(STEP_Y);
  localparam logic [10:0] H_ACTIVE_C = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACTIVE_C = 11'(V_ACTIVE);
  localparam logic [COLOR_BITS-1:0] MAX = {COLOR_BITS{1'b1}};

  typedef enum logic [1:0] {
    FG_MAGENTA = 2'd0,
    FG_YELLOW  = 2'd1,
    FG_CYAN    = 2'd2
  } fg_t;

  fg_t fg_q, fg_d;

  logic [10:0] x_left, y_bottom, x_nx, y_nx;
  logic        dir_x, dir_y, dir_x_nx, dir_y_nx;
  logic        hit_x, hit_y, tick, any_hit;
  logic [10:0] px_x, px_y;
  logic        on_rect;
  logic [COLOR_BITS-1:0] red_d, green_d, blue_d;
  logic [COLOR_BITS-1:0] red_q, green_q, blue_q;
  logic        bounce_q;

  // First blanked line, column 0: safely outside the visible frame.
  assign tick    = vga.enable && (vga.pos_h == 10'd0) && ({1'b0, vga.pos_v} == V_ACTIVE_C);
  assign any_hit = hit_x || hit_y;

  always_comb begin
    x_nx     = x_left;
    dir_x_nx = dir_x;
    hit_x    = 1'b0;
    if (dir_x) begin
      if (x_left + WIDTH_C + STEP_X_C > H_ACTIVE_C) begin
        x_nx     = H_ACTIVE_C - WIDTH_C;
        dir_x_nx = 1'b0;
        hit_x    = 1'b1;
      end else begin
        x_nx = x_left + STEP_X_C;
      end
    end else if (x_left < STEP_X_C) begin
      x_nx     = '0;
      dir_x_nx = 1'b1;
      hit_x    = 1'b1;
    end else begin
      x_nx = x_left - STEP_X_C;
    end
  end

  always_comb begin
    y_nx     = y_bottom;
    dir_y_nx = dir_y;
    hit_y    = 1'b0;
    if (dir_y) begin
      if (y_bottom + HEIGHT_C + STEP_Y_C > V_ACTIVE_C) begin
        y_nx     = V_ACTIVE_C - HEIGHT_C;
        dir_y_nx = 1'b0;
        hit_y    = 1'b1;
      end else begin
        y_nx = y_bottom + STEP_Y_C;
      end
    end else if (y_bottom < STEP_Y_C) begin
      y_nx     = '0;
      dir_y_nx = 1'b1;
      hit_y    = 1'b1;
    end else begin
      y_nx = y_bottom - STEP_Y_C;
    end
  end

  // A corner hit still advances the colour by a single step.
  always_comb begin
    fg_d = fg_q;
    if (tick && any_hit) begin
      case (fg_q)
        FG_MAGENTA: fg_d = FG_YELLOW;
        FG_YELLOW:  fg_d = FG_CYAN;
        default:    fg_d = FG_MAGENTA;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) fg_q <= FG_MAGENTA;
    else     fg_q <= fg_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_left   <= X_START_C;
      y_bottom <= Y_START_C;
      dir_x    <= 1'b1;
      dir_y    <= 1'b1;
      bounce_q <= 1'b0;
    end else begin
      if (tick) begin
        x_left   <= x_nx;
        y_bottom <= y_nx;
        dir_x    <= dir_x_nx;
        dir_y    <= dir_y_nx;
      end
      bounce_q <= tick && any_hit;
    end
  end

  // Cartesian y grows upward from the bottom of the active area.
  assign px_x    = {1'b0, vga.pos_h};
  assign px_y    = V_ACTIVE_C - {1'b0, vga.pos_v};
  assign on_rect = (px_x >= x_left) && (px_x < x_left + WIDTH_C) &&
                   (px_y >= y_bottom) && (px_y < y_bottom + HEIGHT_C);

  always_comb begin
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (!vga.blank) begin
      if (on_rect) begin
        case (fg_q)
          FG_MAGENTA: begin red_d = MAX; blue_d  = MAX; end
          FG_YELLOW:  begin red_d = MAX; green_d = MAX; end
          default:    begin green_d = MAX; blue_d = MAX; end
        endcase
      end else begin
        green_d = MAX;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign vga.red    = red_q;
  assign vga.green  = green_q;
  assign vga.blue   = blue_q;
  assign vga.bounce = bounce_q;

endmodule

// File: tb/tb_vga_bounce_rect.sv
// Scoreboard bench: three renderers (default start, near right edge, near a corner)
// share one raster stream; expected pixels/bounce are queued and checked a cycle later.
module tb_vga_bounce_rect;

  localparam logic [11:0] MAG = 12'hF0F;
  localparam logic [11:0] YEL = 12'hFF0;
  localparam logic [11:0] BG  = 12'h0F0;
  localparam logic [11:0] BLK = 12'h000;

  typedef struct {
    int          due;
    int          dut;
    string       name;
    logic [11:0] rgb;
    logic        bnc;
  } item_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] pos_h = '0;
  logic [9:0] pos_v = '0;
  logic       blank = 1'b1;
  logic       enable = 1'b0;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  item_t      sb[$];

  logic [11:0] rgb_o [3];
  logic        bnc_o [3];

  vga_bounce_rect_if #(.COLOR_BITS(4)) if_a ();
  vga_bounce_rect_if #(.COLOR_BITS(4)) if_b ();
  vga_bounce_rect_if #(.COLOR_BITS(4)) if_c ();

  assign if_a.pos_h = pos_h;  assign if_a.pos_v = pos_v;
  assign if_a.blank = blank;  assign if_a.enable = enable;
  assign if_b.pos_h = pos_h;  assign if_b.pos_v = pos_v;
  assign if_b.blank = blank;  assign if_b.enable = enable;
  assign if_c.pos_h = pos_h;  assign if_c.pos_v = pos_v;
  assign if_c.blank = blank;  assign if_c.enable = enable;

  assign rgb_o[0] = {if_a.red, if_a.green, if_a.blue};
  assign rgb_o[1] = {if_b.red, if_b.green, if_b.blue};
  assign rgb_o[2] = {if_c.red, if_c.green, if_c.blue};
  assign bnc_o[0] = if_a.bounce;
  assign bnc_o[1] = if_b.bounce;
  assign bnc_o[2] = if_c.bounce;

  vga_bounce_rect dut_a (.clk(clk), .rst(rst), .vga(if_a));
  vga_bounce_rect #(.X_START(616)) dut_b (.clk(clk), .rst(rst), .vga(if_b));
  vga_bounce_rect #(.X_START(620), .Y_START(380)) dut_c (.clk(clk), .rst(rst), .vga(if_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic apply(input int h, input int v, input bit bl, input bit en);
    @(posedge clk);
    #1;
    pos_h  = 10'(h);
    pos_v  = 10'(v);
    blank  = bl;
    enable = en;
  endtask

  task automatic expect_px(input int d, input string n, input logic [11:0] rgb, input logic bn);
    item_t it;
    it.due  = cyc + 1;
    it.dut  = d;
    it.name = n;
    it.rgb  = rgb;
    it.bnc  = bn;
    sb.push_back(it);
  endtask

  task automatic frame_tick(input bit en, input bit ba, input bit bb, input bit bc, input string n);
    apply(0, 480, 1, en);
    expect_px(0, n, BLK, ba);
    expect_px(1, n, BLK, bb);
    expect_px(2, n, BLK, bc);
    apply(1, 480, 1, en);
    expect_px(0, {n, "_after"}, BLK, 1'b0);
    expect_px(1, {n, "_after"}, BLK, 1'b0);
    expect_px(2, {n, "_after"}, BLK, 1'b0);
  endtask

  // Monitor: output is presented every cycle; compare whatever is due now.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        it = sb.pop_front();
        checks++;
        if (it.due != cyc || rgb_o[it.dut] !== it.rgb || bnc_o[it.dut] !== it.bnc) begin
          errors++;
          $display("FAIL %s dut%0d: got rgb=%h bounce=%b, want rgb=%h bounce=%b (due %0d now %0d)",
                   it.name, it.dut, rgb_o[it.dut], bnc_o[it.dut], it.rgb, it.bnc, it.due, cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held 3 cycles while an on-rect pixel is presented
    for (int i = 0; i < 3; i++) begin
      apply(320, 200, 0, 1);
      rst = 1'b1;
      expect_px(0, "reset_a", BLK, 1'b0);
      expect_px(1, "reset_b", BLK, 1'b0);
      expect_px(2, "reset_c", BLK, 1'b0);
    end

    apply(320, 200, 0, 1); rst = 1'b0;
    expect_px(0, "a_on_320", MAG, 1'b0);
    expect_px(1, "b_bg_320", BG, 1'b0);
    expect_px(2, "c_bg_320", BG, 1'b0);
    apply(319, 200, 0, 1); expect_px(0, "a_left_out", BG, 1'b0);
    apply(320, 200, 1, 1); expect_px(0, "a_blank", BLK, 1'b0);
    apply(339, 200, 0, 1); expect_px(0, "a_right_in", MAG, 1'b0);
    apply(340, 200, 0, 1); expect_px(0, "a_right_out", BG, 1'b0);
    apply(330, 140, 0, 1); expect_px(0, "a_top_out", BG, 1'b0);
    apply(330, 141, 0, 1); expect_px(0, "a_top_in", MAG, 1'b0);
    apply(330, 240, 0, 1); expect_px(0, "a_bot_in", MAG, 1'b0);
    apply(330, 241, 0, 1); expect_px(0, "a_bot_out", BG, 1'b0);

    // Tick 1: A -> 322/241, B -> 618, C corner -> yellow, both dirs reversed
    frame_tick(1, 0, 0, 1, "tick1");
    apply(321, 200, 0, 1); expect_px(0, "a_t1_321", BG, 1'b0);
    apply(322, 200, 0, 1); expect_px(0, "a_t1_322", MAG, 1'b0);
    apply(341, 200, 0, 1); expect_px(0, "a_t1_341", MAG, 1'b0);
    apply(342, 200, 0, 1); expect_px(0, "a_t1_342", BG, 1'b0);
    apply(330, 140, 0, 1); expect_px(0, "a_t1_y340", MAG, 1'b0);
    apply(330, 240, 0, 1); expect_px(0, "a_t1_y240", BG, 1'b0);
    apply(617, 200, 0, 1); expect_px(1, "b_t1_617", BG, 1'b0);
    apply(618, 200, 0, 1); expect_px(1, "b_t1_618", MAG, 1'b0);
    apply(637, 200, 0, 1); expect_px(1, "b_t1_637", MAG, 1'b0);
    apply(638, 200, 0, 1); expect_px(1, "b_t1_638", BG, 1'b0);
    apply(620, 50, 0, 1);  expect_px(2, "c_t1_yel", YEL, 1'b0);
    apply(619, 50, 0, 1);  expect_px(2, "c_t1_619", BG, 1'b0);
    apply(620, 100, 0, 1); expect_px(2, "c_t1_y380", YEL, 1'b0);
    apply(620, 101, 0, 1); expect_px(2, "c_t1_y379", BG, 1'b0);

    frame_tick(1, 0, 0, 0, "tick2");
    apply(620, 200, 0, 1); expect_px(1, "b_t2_620", MAG, 1'b0);
    apply(619, 200, 0, 1); expect_px(1, "b_t2_619", BG, 1'b0);

    frame_tick(1, 0, 1, 0, "tick3");
    apply(620, 200, 0, 1); expect_px(1, "b_t3_620", YEL, 1'b0);
    apply(619, 200, 0, 1); expect_px(1, "b_t3_619", BG, 1'b0);

    frame_tick(1, 0, 0, 0, "tick4");
    apply(618, 200, 0, 1); expect_px(1, "b_t4_618", YEL, 1'b0);
    apply(617, 200, 0, 1); expect_px(1, "b_t4_617", BG, 1'b0);

    // Motion disabled: two ticks leave everything frozen
    frame_tick(0, 0, 0, 0, "freeze1");
    frame_tick(0, 0, 0, 0, "freeze2");
    apply(327, 200, 0, 1); expect_px(0, "a_frz_327", BG, 1'b0);
    apply(328, 200, 0, 1); expect_px(0, "a_frz_328", MAG, 1'b0);
    apply(330, 236, 0, 1); expect_px(0, "a_frz_y244", MAG, 1'b0);
    apply(330, 237, 0, 1); expect_px(0, "a_frz_y243", BG, 1'b0);
    apply(618, 200, 0, 1); expect_px(1, "b_frz_618", YEL, 1'b0);
    apply(617, 200, 0, 1); expect_px(1, "b_frz_617", BG, 1'b0);
    apply(614, 50, 0, 1);  expect_px(2, "c_frz_614", YEL, 1'b0);
    apply(613, 50, 0, 1);  expect_px(2, "c_frz_613", BG, 1'b0);
    apply(620, 103, 0, 1); expect_px(2, "c_frz_y377", YEL, 1'b0);
    apply(620, 104, 0, 1); expect_px(2, "c_frz_y376", BG, 1'b0);

    // Reset in the middle of an active line
    apply(330, 200, 0, 1); expect_px(0, "a_pre_rst", MAG, 1'b0);
    apply(330, 200, 0, 1); rst = 1'b1;
    expect_px(0, "a_mid_rst", BLK, 1'b0);
    expect_px(1, "b_mid_rst", BLK, 1'b0);
    expect_px(2, "c_mid_rst", BLK, 1'b0);
    apply(340, 200, 0, 1); rst = 1'b0;
    expect_px(0, "a_rst_340", BG, 1'b0);
    apply(319, 200, 0, 1); expect_px(0, "a_rst_319", BG, 1'b0);
    apply(320, 200, 0, 1); expect_px(0, "a_rst_320", MAG, 1'b0);
    apply(616, 200, 0, 1); expect_px(1, "b_rst_616", MAG, 1'b0);
    apply(620, 50, 0, 1);  expect_px(2, "c_rst_mag", MAG, 1'b0);
    apply(620, 100, 0, 1); expect_px(2, "c_rst_y380", MAG, 1'b0);
    apply(620, 101, 0, 1); expect_px(2, "c_rst_y379", BG, 1'b0);

    apply(0, 0, 1, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      errors += sb.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
